// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: scanned display bus (i_cs/i_seg) and decoded frame/status outputs; master = display side, slave = decoder
interface seg_scan_decoder_if;
  logic [7:0]  i_cs;
  logic [7:0]  i_seg;
  logic [31:0] o_digits;
  logic [7:0]  o_dp;
  logic        o_frame_valid;
  logic        o_cs_err;
  logic        o_seg_err;
  logic        o_stale;
  modport master (output i_cs, i_seg, input o_digits, o_dp, o_frame_valid, o_cs_err, o_seg_err, o_stale);
  modport slave (input i_cs, i_seg, output o_digits, o_dp, o_frame_valid, o_cs_err, o_seg_err, o_stale);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a scanned 7-segment bus, filters ghosting, decodes digits and publishes 8-digit frames
// Ports: i_clk, i_rst (sync, active-high); io_bus.i_cs/i_seg (active-low scan inputs);
// io_bus.o_digits/o_dp (frame), o_frame_valid, o_cs_err, o_seg_err (pulses), o_stale (watchdog level).
// Macro SEG_SCAN_TIMEOUT_EN enables the frame watchdog; otherwise o_stale is tied low.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic i_clk,
  input logic i_rst,
  seg_scan_decoder_if.slave io_bus
);
  logic [7:0]  r_cs, r_seg, r_cs_d, r_seg_d, r_cnt, r_seen, r_dp_sh;
  logic [31:0] r_shadow;
  logic [7:0]  w_sel, w_cnt_nxt;
  logic [2:0]  w_idx;
  logic [3:0]  w_code;
  logic        w_multi, w_valid, w_cap, w_bad, w_pub;
  always_comb begin
    w_sel = ~r_cs;
    w_multi = (w_sel & (w_sel - 8'd1)) != 8'd0;
    w_valid = (w_sel != 8'd0) && !w_multi;
    w_idx = '0;
    for (int i = 0; i < 8; i++) if (w_sel[i]) w_idx = 3'(i);
    // a changed pair restarts the dwell; the counter saturates so capture fires once per dwell
    w_cnt_nxt = !w_valid ? 8'd0 : ({r_cs, r_seg} != {r_cs_d, r_seg_d}) ? 8'd1 : (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    w_cap = w_valid && (w_cnt_nxt == 8'(STABLE_CYC));
    w_pub = r_seen == 8'hFF;
    w_bad = 1'b0;
    case (~r_seg[6:0])
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h40: w_code = 4'hE;
      7'h00: w_code = 4'hF;
      default: begin
        w_code = 4'hA;
        w_bad = 1'b1;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs <= 8'hFF;
      r_seg <= 8'hFF;
      r_cs_d <= 8'hFF;
      r_seg_d <= 8'hFF;
      r_cnt <= 8'd0;
      r_seen <= 8'd0;
      r_dp_sh <= 8'd0;
      r_shadow <= 32'hFFFF_FFFF;
      io_bus.o_digits <= 32'hFFFF_FFFF;
      io_bus.o_dp <= 8'd0;
      io_bus.o_frame_valid <= 1'b0;
      io_bus.o_cs_err <= 1'b0;
      io_bus.o_seg_err <= 1'b0;
    end else begin
      r_cs <= io_bus.i_cs;
      r_seg <= io_bus.i_seg;
      r_cs_d <= r_cs;
      r_seg_d <= r_seg;
      r_cnt <= w_cnt_nxt;
      io_bus.o_cs_err <= w_multi;
      io_bus.o_seg_err <= w_cap && w_bad;
      io_bus.o_frame_valid <= w_pub;
      // publishing uses the pre-edge shadow, so a coincident capture lands in the next frame
      r_seen <= (w_pub ? 8'h00 : r_seen) | (w_cap ? 8'h01 << w_idx : 8'h00);
      if (w_pub) begin
        io_bus.o_digits <= r_shadow;
        io_bus.o_dp <= r_dp_sh;
      end
      if (w_cap) begin
        r_shadow[{w_idx, 2'b00} +: 4] <= w_code;
        r_dp_sh[w_idx] <= ~r_seg[7];
      end
    end
  end
`ifdef SEG_SCAN_TIMEOUT_EN
  logic [31:0] r_wd;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd <= 32'd0;
      io_bus.o_stale <= 1'b1;
    end else if (w_pub) begin
      r_wd <= 32'd0;
      io_bus.o_stale <= 1'b0;
    end else begin
      r_wd <= (r_wd == 32'hFFFF_FFFF) ? r_wd : r_wd + 32'd1;
      if (r_wd + 32'd1 >= 32'(TIMEOUT_CYC)) io_bus.o_stale <= 1'b1;
    end
  end
`else
  assign io_bus.o_stale = TIMEOUT_CYC < 0;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and random scans checked against a dwell-level display model
module tb_seg_scan_decoder;
  localparam int STABLE = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};
  typedef struct {logic [31:0] d; logic [7:0] p;} frame_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_scan_decoder_if bus();
  seg_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(100)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  frame_t exp_q[$];
  int n_vec = 0, n_err = 0, n_fv = 0, n_cs = 0, n_se = 0;
  int exp_fv = 0, exp_cs = 0, exp_se = 0, cyc = 0, last_fv = 0;
  logic [3:0] m_code [8];
  logic [7:0] m_dp, m_seen, last_p;
  logic [31:0] last_d;
  logic [6:0] g [8];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int decode(logic [6:0] p);
    for (int c = 0; c < 16; c++) if ((c < 10 || c > 13) && GLYPH[c] == p) return c;
    return -1;
  endfunction
  always @(negedge clk) begin
    frame_t f;
    cyc++;
    if (!rst) begin
      if (bus.o_frame_valid) begin
        n_fv++;
        last_fv = cyc;
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          chk("frame_digits", bus.o_digits, f.d);
          chk("frame_dp", bus.o_dp, f.p);
        end
      end
      n_cs += int'(bus.o_cs_err);
      n_se += int'(bus.o_seg_err);
    end
  end
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_code[i] = 4'hF;
    m_dp = 8'h00;
    m_seen = 8'h00;
    last_d = 32'hFFFF_FFFF;
    last_p = 8'h00;
  endtask
  task automatic dwell(logic [7:0] cs, logic [7:0] seg, int n);
    int k = 0, nz = 0, c;
    frame_t f;
    bus.i_cs = cs;
    bus.i_seg = seg;
    for (int i = 0; i < 8; i++) if (!cs[i]) begin nz++; k = i; end
    if (nz > 1) exp_cs += n;
    if (nz == 1 && n >= STABLE) begin
      c = decode(~seg[6:0]);
      if (c < 0) begin c = 10; exp_se++; end
      m_code[k] = 4'(c);
      m_dp[k] = ~seg[7];
      m_seen[k] = 1'b1;
      if (m_seen == 8'hFF) begin
        for (int i = 0; i < 8; i++) f.d[4*i +: 4] = m_code[i];
        f.p = m_dp;
        exp_q.push_back(f);
        exp_fv++;
        last_d = f.d;
        last_p = f.p;
        m_seen = 8'h00;
      end
    end
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scan(logic [6:0] gl [8], logic [7:0] dp, int len, int gap, int lo, int hi, int ghost);
    for (int d = lo; d <= hi; d++) begin
      if (d == ghost) dwell(~(8'h01 << d), {1'b1, ~GLYPH[8]}, 3);
      dwell(~(8'h01 << d), {~dp[d], ~gl[d]}, len);
      dwell(8'hFF, 8'hFF, gap);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      bus.i_cs = 8'($urandom);
      bus.i_seg = 8'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("reset_digits", bus.o_digits, 32'hFFFF_FFFF);
    chk("reset_dp", bus.o_dp, 8'h00);
    chk("reset_pulses", {bus.o_frame_valid, bus.o_cs_err, bus.o_seg_err}, 3'b000);
`ifdef SEG_SCAN_TIMEOUT_EN
    chk("reset_stale", bus.o_stale, 1);
`else
    chk("reset_stale", bus.o_stale, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_cs = 8'hFF;
    bus.i_seg = 8'hFF;
    model_reset();
  endtask
  task automatic check_counts(string tag);
    dwell(8'hFF, 8'hFF, 8);
    @(negedge clk);
    #1;
    chk({tag, "_frames"}, n_fv, exp_fv);
    chk({tag, "_cs_err"}, n_cs, exp_cs);
    chk({tag, "_seg_err"}, n_se, exp_se);
    chk({tag, "_digits"}, bus.o_digits, last_d);
    chk({tag, "_dp"}, bus.o_dp, last_p);
    chk({tag, "_pending"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int code;
    logic [7:0] cs;
    bus.i_cs = 8'hFF;
    bus.i_seg = 8'hFF;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    g = '{GLYPH[1], GLYPH[2], GLYPH[14], GLYPH[3], GLYPH[4], GLYPH[14], GLYPH[5], GLYPH[6]};
    scan(g, 8'h00, 10, 2, 0, 7, -1);
    check_counts("clean1");
    chk("clean_digits", bus.o_digits, 32'h65E43E21);
    scan(g, 8'h00, 10, 2, 0, 7, -1);
    check_counts("clean2");
    scan(g, 8'hA5, 10, 2, 0, 7, 2);
    check_counts("ghost");
    chk("ghost_digits", bus.o_digits, 32'h65E43E21);
    dwell(8'hFC, 8'hFF, 5);
    dwell(8'hFF, 8'hFF, 2);
    check_counts("cs_err");
    g[3] = 7'h49;
    scan(g, 8'h00, 10, 2, 0, 7, -1);
    check_counts("seg_err");
    chk("seg_err_nibble", bus.o_digits[15:12], 4'hA);
    for (int n = 0; n < 60; n++) begin
      code = $urandom_range(0, 9);
      cs = code < 7 ? ~(8'h01 << $urandom_range(0, 7)) : code < 9 ? ~((8'h01 << $urandom_range(0, 3)) | (8'h10 << $urandom_range(0, 3))) : 8'hFF;
      code = $urandom_range(0, 11);
      dwell(cs, $urandom_range(0, 9) < 7 ? {1'($urandom), ~GLYPH[code < 10 ? code : code + 4]} : 8'($urandom), $urandom_range(1, 12));
      dwell(8'hFF, 8'hFF, $urandom_range(1, 3));
    end
    for (int s = 0; s < 3; s++) begin
      for (int d = 0; d < 8; d++) begin
        code = $urandom_range(0, 11);
        g[d] = GLYPH[code < 10 ? code : code + 4];
      end
      scan(g, 8'($urandom), $urandom_range(4, 8), $urandom_range(1, 2), 0, 7, -1);
    end
    check_counts("random");
    scan(g, 8'h0F, 10, 2, 0, 4, -1);
    do_reset();
    scan(g, 8'h0F, 10, 2, 5, 7, -1);
    check_counts("midreset_partial");
    scan(g, 8'h0F, 10, 2, 0, 7, -1);
    check_counts("midreset_full");
`ifdef SEG_SCAN_TIMEOUT_EN
    chk("stale_after_frame", bus.o_stale, 0);
    for (int w = 0; w < 300 && !bus.o_stale; w++) begin
      @(negedge clk);
      #1;
    end
    chk("stale_delay", cyc - last_fv, 100);
`else
    repeat (150) @(posedge clk);
    #1;
    chk("stale_off", bus.o_stale, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
